// File: rtl/sr_feeder.sv
// Line-buffer feeder: loads BUFFER_SIZE SRAM words into a shift_reg, then recirculates it num_pass times.
// Optional stall-cycle performance counter built when FEEDER_PERF_EN is defined.
module sr_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 9,
  parameter int ADDR_WIDTH  = 10,
  parameter int PASS_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [PASS_WIDTH-1:0] num_pass,
  input  logic                  stall,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  sr_in_valid,
  output logic                  sr_read_en,
  output logic [DATA_WIDTH-1:0] sr_data,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           perf_stall_cnt
);

  localparam int BW = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int RW = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RECIRC, S_LAST, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [PASS_WIDTH-1:0]   num_pass_q;
  logic [RW-1:0]           rd_cnt;
  logic [BW-1:0]           load_cnt, beat_cnt;
  logic [PASS_WIDTH-1:0]   pass_cnt;
  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   skid_data [2];
  logic [1:0]              skid_cnt, skid_cnt_d;
  logic                    accept, skid_any, emit_load, emit_recirc, push, pop, issue;
  logic                    load_last, recirc_last, busy_d, done_d;
  logic [ADDR_WIDTH-1:0]   issue_addr;
  logic [DATA_WIDTH-1:0]   emit_word;

  // A read issued in the first stall cycle returns after the skid already holds
  // the previous word, so the skid has two slots; issue is throttled so at most
  // two words are ever unemitted.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    accept      = (state_q == S_IDLE) && start;
    skid_any    = (skid_cnt != 2'd0);
    emit_load   = (state_q == S_LOAD) && !stall && (rvalid_q || skid_any);
    emit_recirc = (state_q == S_RECIRC) && !stall;
    emit_word   = skid_any ? skid_data[0] : mem_rdata;
    pop         = emit_load && skid_any;
    push        = rvalid_q && !(emit_load && !skid_any);
    skid_cnt_d  = skid_cnt + {1'b0, push} - {1'b0, pop};
    issue       = accept ||
                  ((state_q == S_LOAD) && !stall && (rd_cnt != RW'(BUFFER_SIZE)) &&
                   ((skid_cnt_d + {1'b0, mem_rd_en}) <= 2'd1));
    issue_addr  = accept ? base_addr : base_q + ADDR_WIDTH'(rd_cnt);
    load_last   = emit_load && (load_cnt == BW'(BUFFER_SIZE - 1));
    recirc_last = emit_recirc && (beat_cnt == BW'(BUFFER_SIZE - 1)) &&
                  (pass_cnt == num_pass_q - PASS_WIDTH'(1));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)       state_d = S_LOAD;
      S_LOAD:   if (load_last)   state_d = (num_pass_q != '0) ? S_RECIRC : S_LAST;
      S_RECIRC: if (recirc_last) state_d = S_LAST;
      S_LAST:                    state_d = S_DONE;
      S_DONE:                    state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs, registered below so they describe the state being entered
  always_comb begin
    busy_d = (state_d == S_LOAD) || (state_d == S_RECIRC) || (state_d == S_LAST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= '0;
      num_pass_q  <= '0;
      rd_cnt      <= '0;
      load_cnt    <= '0;
      beat_cnt    <= '0;
      pass_cnt    <= '0;
      rvalid_q    <= 1'b0;
      skid_cnt    <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      sr_in_valid <= 1'b0;
      sr_read_en  <= 1'b0;
      sr_data     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      mem_rd_en   <= issue;
      rvalid_q    <= mem_rd_en;
      skid_cnt    <= skid_cnt_d;
      sr_in_valid <= emit_load || emit_recirc;
      sr_read_en  <= emit_load;
      sr_data     <= emit_load ? emit_word : '0;
      if (issue) mem_addr <= issue_addr;

      if (accept) begin
        base_q     <= base_addr;
        num_pass_q <= num_pass;
        rd_cnt     <= RW'(1);
        load_cnt   <= '0;
        beat_cnt   <= '0;
        pass_cnt   <= '0;
      end else begin
        if (issue)     rd_cnt   <= rd_cnt + RW'(1);
        if (emit_load) load_cnt <= load_cnt + BW'(1);
        if (emit_recirc) begin
          if (beat_cnt == BW'(BUFFER_SIZE - 1)) begin
            beat_cnt <= '0;
            pass_cnt <= pass_cnt + PASS_WIDTH'(1);
          end else begin
            beat_cnt <= beat_cnt + BW'(1);
          end
        end
      end
    end
  end

  // NOTE: skid storage is not reset; skid_cnt alone says which slots hold data.
  always_ff @(posedge clk) begin
    if (pop)  skid_data[0]            <= skid_data[1];
    if (push) skid_data[skid_cnt_d[1]] <= mem_rdata;
  end

`ifdef FEEDER_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                               perf_q <= '0;
    else if (accept)                          perf_q <= '0;
    else if (busy && stall && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_feeder.sv
// Directed self-checking bench for sr_feeder: load/recirc sequencing, wrap, stall/skid, ignored starts, mid-job reset.
module tb_sr_feeder;

  localparam int DW = 8;
  localparam int BS = 9;
  localparam int AW = 10;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [PW-1:0] num_pass;
  logic          stall;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          sr_in_valid;
  logic          sr_read_en;
  logic [DW-1:0] sr_data;
  logic          busy;
  logic          done;
  logic [15:0]   perf_stall_cnt;

  sr_feeder #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .ADDR_WIDTH(AW), .PASS_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_pass(num_pass),
    .stall(stall), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sr_in_valid(sr_in_valid), .sr_read_en(sr_read_en), .sr_data(sr_data),
    .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    logic [15:0] t;
    t = 16'(a) * 16'd7 + 16'd3;
    return t[7:0];
  endfunction

  // SRAM model: data valid exactly one cycle after the read strobe
  always @(posedge clk) mem_rdata <= mem_rd_en ? pat(mem_addr) : 8'hEE;

  logic [DW-1:0] b_data [64];
  logic          b_re   [64];
  int            b_cyc  [64];
  logic [AW-1:0] a_log  [64];
  int            a_cyc  [64];
  int nb, na, done_cnt, done_cyc;
  logic busy_at_done;

  always @(negedge clk) begin
    if (sr_in_valid && nb < 64) begin
      b_data[nb] = sr_data; b_re[nb] = sr_read_en; b_cyc[nb] = cyc; nb++;
    end
    if (mem_rd_en && na < 64) begin
      a_log[na] = mem_addr; a_cyc[na] = cyc; na++;
    end
    if (done) begin
      done_cnt++; done_cyc = cyc; busy_at_done = busy;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int s;

  task automatic run_job(input logic [AW-1:0] base, input logic [PW-1:0] np,
                         input int stall_lo, input int stall_hi, input int busy_k,
                         input bit pulse_done, input int rst_k);
    bit saw_done;
    bit timed_out;
    int post;
    @(posedge clk); #2;
    nb = 0; na = 0; done_cnt = 0; done_cyc = -1; busy_at_done = 1'b1;
    start = 1'b1; base_addr = base; num_pass = np; stall = 1'b0;
    s = cyc; saw_done = 0; timed_out = 1; post = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #2;
      start     = (k == busy_k);
      base_addr = (k == busy_k) ? 10'h200 : base;
      stall     = (k >= stall_lo) && (k <= stall_hi);
      if (rst_k != 0 && k == rst_k) rst_n = 1'b0;
      if (rst_k != 0 && k == rst_k + 1) begin
        check("rst_valid", sr_in_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_data",  sr_data, 0);
        rst_n = 1'b1;
      end
      if (done && !saw_done) begin
        saw_done = 1;
        if (pulse_done) start = 1'b1;
      end
      if (saw_done || (rst_k != 0 && k > rst_k + 1)) post++;
      if (post == 6) begin
        timed_out = 0;
        break;
      end
    end
    start = 1'b0; stall = 1'b0;
    if (timed_out) check("timeout", 1, 0);
  endtask

  task automatic verify_job(input logic [AW-1:0] base, input int np, input int stall_len);
    int n;
    logic [AW-1:0] a;
    int exp_perf;
    n = BS * (1 + np);
    check("beats", nb, n);
    for (int i = 0; i < nb; i++) begin
      a = base + AW'(i);
      if (i < BS) begin
        check($sformatf("load_data%0d", i), b_data[i], pat(a));
        check($sformatf("load_re%0d", i), b_re[i], 1);
      end else begin
        check($sformatf("rc_data%0d", i), b_data[i], 0);
        check($sformatf("rc_re%0d", i), b_re[i], 0);
      end
    end
    check("reads", na, BS);
    for (int i = 0; i < na; i++) begin
      a = base + AW'(i);
      check($sformatf("addr%0d", i), a_log[i], a);
    end
    check("first_rd", a_cyc[0], s + 1);
    check("first_beat", b_cyc[0], s + 3);
    check("span", b_cyc[nb-1] - b_cyc[0], n - 1 + stall_len);
    check("done_cnt", done_cnt, 1);
    check("done_cyc", done_cyc, b_cyc[nb-1] + 1);
    check("busy_at_done", busy_at_done, 0);
    check("busy_end", busy, 0);
`ifdef FEEDER_PERF_EN
    exp_perf = stall_len;
`else
    exp_perf = 0;
`endif
    check("perf", perf_stall_cnt, exp_perf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    nb = 0; na = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b1; base_addr = 10'h123; num_pass = 8'd1; stall = 1'b0;

    // 1: reset held with start asserted
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_en0", mem_rd_en, 0);
    check("rst_addr0",  mem_addr, 0);
    check("rst_valid0", sr_in_valid, 0);
    check("rst_re0",    sr_read_en, 0);
    check("rst_data0",  sr_data, 0);
    check("rst_busy0",  busy, 0);
    check("rst_done0",  done, 0);
    check("rst_perf0",  perf_stall_cnt, 0);
    start = 1'b0;
    rst_n = 1'b1;
    nb = 0; na = 0;
    repeat (5) @(posedge clk);
    #2;
    check("idle_beats", nb, 0);
    check("idle_reads", na, 0);
    check("idle_busy", busy, 0);

    // 2: plain job with two recirculation passes
    run_job(10'h010, 8'd2, 0, 0, 0, 0, 0);
    verify_job(10'h010, 2, 0);

    // 3: address wrap, no recirculation
    run_job(10'h3FC, 8'd0, 0, 0, 0, 0, 0);
    verify_job(10'h3FC, 0, 0);

    // 4: three stall cycles mid-load
    run_job(10'h020, 8'd1, 5, 7, 0, 0, 0);
    verify_job(10'h020, 1, 3);
    check("rd_gap", a_cyc[5] >= s + 9, 1);

    // 5a: start pulsed while busy and in the done cycle
    run_job(10'h040, 8'd1, 0, 0, 10, 1, 0);
    verify_job(10'h040, 1, 0);

    // 5b: reset mid-recirculation, then a fresh job
    run_job(10'h080, 8'd3, 0, 0, 0, 0, 20);
    check("rst_no_done", done_cnt, 0);
    check("rst_idle_busy", busy, 0);
    run_job(10'h100, 8'd1, 0, 0, 0, 0, 0);
    verify_job(10'h100, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
